// File: rtl/dds_gen_param.sv
// Parametrised DDS: phase accumulator, four waveforms, wrap-synchronous switching.
// Optional build macro DDS_SWEEP_EN adds a 'sweep' input that steps fw once per wrap.
module dds_gen_param #(
    parameter int unsigned      ACC_W   = 32,
    parameter int unsigned      ADDR_W  = 10,
    parameter int unsigned      DAC_W   = 10,
    parameter logic [ACC_W-1:0] FW_MIN  = ACC_W'(4295),
    parameter logic [ACC_W-1:0] FW_MAX  = ACC_W'(429497),
    parameter logic [ACC_W-1:0] FW_STEP = ACC_W'(4295),
    parameter logic [ACC_W-1:0] PW_STEP = ACC_W'(32'h4000_0000)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic [1:0]       wave_sel,
    input  logic             fre_adjust,
    input  logic             pha_adjust,
`ifdef DDS_SWEEP_EN
    input  logic             sweep,
`endif
    output logic             start_flag,
    output logic             dac_valid,
    output logic [DAC_W-1:0] dac_data
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q, fw_q, poff_q;
    logic [ACC_W-1:0]   acc_d, fw_d, poff_d;
    logic [1:0]         wave_cur_q, wave1_q;
    logic               first_q, fre_q, pha_q;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               v1_q, sf1_q, v2_q, sf2_q;
    logic [DAC_W-1:0]   data_q, sample_d;

    logic [ACC_W:0]     acc_sum, fw_sum;
    logic               run, start_run, wrap;
    logic               fre_edge, pha_edge, sweep_step, fw_step;
    logic [ADDR_W-2:0]  tri_lo;

    // Sine table built at elaboration (Bhaskara approximation, offset-binary).
    function automatic logic [DAC_W-1:0] sine_at(input int k);
        longint n, h, t, amp, s;
        n   = longint'(1) << (ADDR_W - 1);
        h   = longint'(k) % n;
        t   = h * (n - h);
        amp = (longint'(1) << (DAC_W - 1)) - 1;
        s   = (16 * t * amp) / (5 * n * n - 4 * t);
        if (longint'(k) < n)
            return DAC_W'(amp + 1 + s);
        return DAC_W'(amp + 1 - s);
    endfunction

    function automatic logic [DAC_W-1:0] ljust(input logic [ADDR_W-1:0] v);
        logic [ADDR_W+DAC_W-1:0] w;
        w = {v, {DAC_W{1'b0}}};
        return w[ADDR_W+DAC_W-1 -: DAC_W];
    endfunction

    logic [DAC_W-1:0] sine_rom [2**ADDR_W];

    for (genvar g = 0; g < 2**ADDR_W; g++) begin : g_rom
        assign sine_rom[g] = sine_at(g);
    end

    assign run       = (state_q == RUN) && en;
    assign start_run = (state_q == IDLE) && en;
    assign acc_sum   = {1'b0, acc_q} + {1'b0, fw_q};
    assign wrap      = run && acc_sum[ACC_W];
    assign fre_edge  = fre_adjust && !fre_q;
    assign pha_edge  = pha_adjust && !pha_q;

`ifdef DDS_SWEEP_EN
    assign sweep_step = sweep && wrap;
`else
    assign sweep_step = 1'b0;
`endif

    // A sweep step and a key edge in the same cycle merge into one step.
    assign fw_step = fre_edge || sweep_step;
    assign fw_sum  = {1'b0, fw_q} + {1'b0, FW_STEP};

    always_comb begin
        fw_d = fw_q;
        if (fw_step)
            fw_d = (fw_sum > {1'b0, FW_MAX}) ? FW_MIN : fw_sum[ACC_W-1:0];
    end

    assign poff_d = pha_edge ? poff_q + PW_STEP : poff_q;
    assign acc_d  = run ? acc_sum[ACC_W-1:0] : '0;
    assign addr_d = ADDR_W'((acc_q + poff_q) >> (ACC_W - ADDR_W));
    assign tri_lo = addr_q[ADDR_W-1] ? ~addr_q[ADDR_W-2:0]
                                     : addr_q[ADDR_W-2:0];

    always_comb begin
        sample_d = '0;
        unique case (wave1_q)
            2'b00: sample_d = sine_rom[addr_q];
            2'b01: sample_d = addr_q[ADDR_W-1] ? '0 : '1;
            2'b10: sample_d = ljust({tri_lo, 1'b0});
            2'b11: sample_d = ljust(addr_q);
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            fw_q       <= FW_MIN;
            poff_q     <= '0;
            wave_cur_q <= 2'b00;
            first_q    <= 1'b0;
            fre_q      <= 1'b0;
            pha_q      <= 1'b0;
            addr_q     <= '0;
            wave1_q    <= 2'b00;
            v1_q       <= 1'b0;
            sf1_q      <= 1'b0;
            v2_q       <= 1'b0;
            sf2_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (en) state_q <= RUN;
                RUN:  if (!en) state_q <= IDLE;
            endcase
            acc_q   <= acc_d;
            fw_q    <= fw_d;
            poff_q  <= poff_d;
            fre_q   <= fre_adjust;
            pha_q   <= pha_adjust;
            first_q <= wrap || start_run;
            if (wrap || start_run)
                wave_cur_q <= wave_sel;
            v1_q    <= (state_q == RUN);
            sf1_q   <= (state_q == RUN) && first_q;
            addr_q  <= addr_d;
            wave1_q <= wave_cur_q;
            v2_q    <= v1_q;
            sf2_q   <= sf1_q;
            data_q  <= v1_q ? sample_d : '0;
        end
    end

    assign start_flag = sf2_q;
    assign dac_valid  = v2_q;
    assign dac_data   = data_q;

endmodule

// File: tb/tb_dds_gen_param.sv
// Bench for dds_gen_param (8-bit build): directed steps then random stimulus,
// each cycle compared against a period/phase-level reference model.
module tb_dds_gen_param;

    logic       clk = 1'b0;
    logic       rst, en, fre, pha;
    logic [1:0] wsel;
`ifdef DDS_SWEEP_EN
    logic       sweep;
`endif
    logic       start_flag, dac_valid;
    logic [7:0] dac_data;

    always #5 clk = ~clk;

    dds_gen_param #(
        .ACC_W(8), .ADDR_W(8), .DAC_W(8),
        .FW_MIN(8'd1), .FW_MAX(8'd4), .FW_STEP(8'd1), .PW_STEP(8'd64)
    ) dut (
        .sys_clk(clk), .sys_rst(rst), .en(en), .wave_sel(wsel),
        .fre_adjust(fre), .pha_adjust(pha),
`ifdef DDS_SWEEP_EN
        .sweep(sweep),
`endif
        .start_flag(start_flag), .dac_valid(dac_valid), .dac_data(dac_data)
    );

    typedef struct {
        bit valid;
        bit sf;
        int wave;
        int addr;
    } smp_t;

    smp_t idle_s = '{valid: 1'b0, sf: 1'b0, wave: 0, addr: 0};
    smp_t pipe[$];
    smp_t out;

    bit m_run, m_first, p_fre, p_pha;
    int m_acc, m_fw, m_poff, m_wave;
    int checks = 0;
    int errors = 0;

    function automatic int wave_val(int w, int a);
        case (w)
            1: return (a < 128) ? 255 : 0;
            2: return (a < 128) ? 2 * a : 2 * (255 - a);
            3: return a;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_run = 0; m_first = 0; p_fre = 0; p_pha = 0;
        m_acc = 0; m_fw = 1; m_poff = 0; m_wave = 0;
        pipe.delete();
        pipe.push_back(idle_s);
        out = idle_s;
    endtask

    task automatic model_edge();
        smp_t s;
        bit step, sw, wrapped;
        int nxt;
`ifdef DDS_SWEEP_EN
        sw = sweep;
`else
        sw = 1'b0;
`endif
        if (rst) begin
            model_reset();
        end else begin
            s = idle_s;
            if (m_run) begin
                s.valid = 1;
                s.sf = m_first;
                s.wave = m_wave;
                s.addr = (m_acc + m_poff) % 256;
            end
            out = pipe.pop_front();
            pipe.push_back(s);
            step = fre && !p_fre;
            if (m_run && en) begin
                nxt = m_acc + m_fw;
                wrapped = (nxt >= 256);
                m_acc = nxt % 256;
                m_first = wrapped;
                if (wrapped) begin
                    m_wave = int'(wsel);
                    if (sw) step = 1;
                end
            end else if (m_run) begin
                m_run = 0; m_acc = 0; m_first = 0;
            end else if (en) begin
                m_run = 1; m_acc = 0; m_first = 1; m_wave = int'(wsel);
            end
            if (step) m_fw = (m_fw + 1 > 4) ? 1 : m_fw + 1;
            if (pha && !p_pha) m_poff = (m_poff + 64) % 256;
            p_fre = fre;
            p_pha = pha;
        end
    endtask

    task automatic check();
        int  exp_d;
        real r;
        checks++;
        assert (dac_valid === out.valid) else begin
            errors++;
            $error("FAIL valid: got %0b want %0b", dac_valid, out.valid);
        end
        checks++;
        assert (start_flag === out.sf) else begin
            errors++;
            $error("FAIL start_flag: got %0b want %0b", start_flag, out.sf);
        end
        checks++;
        if (out.valid && out.wave == 0) begin
            r = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * out.addr / 256.0);
            exp_d = int'(r);
            assert (int'(dac_data) >= exp_d - 2 && int'(dac_data) <= exp_d + 2)
            else begin
                errors++;
                $error("FAIL sine a=%0d: got %0d want %0d+-2", out.addr, dac_data, exp_d);
            end
        end else begin
            exp_d = out.valid ? wave_val(out.wave, out.addr) : 0;
            assert (dac_data === 8'(exp_d)) else begin
                errors++;
                $error("FAIL data w=%0d a=%0d: got %0d want %0d",
                       out.wave, out.addr, dac_data, exp_d);
            end
        end
    endtask

    task automatic cycle(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check();
        end
    endtask

    task automatic pulse_fre();
        fre = 1; cycle(1); fre = 0; cycle(1);
    endtask

    task automatic pulse_pha();
        pha = 1; cycle(1); pha = 0; cycle(1);
    endtask

    initial begin
        rst = 1; en = 0; fre = 0; pha = 0; wsel = 2'b11;
`ifdef DDS_SWEEP_EN
        sweep = 0;
`endif
        model_reset();
        cycle(2);
        rst = 0;
        cycle(3);

        en = 1;
        cycle(262);

        fre = 1; cycle(5); fre = 0;
        cycle(140);
        pulse_fre(); cycle(90);
        pulse_fre(); cycle(70);
        pulse_fre(); cycle(260);

        cycle(10);
        pulse_pha(); cycle(50);
        for (int i = 0; i < 3; i++) begin
            pulse_pha(); cycle(20);
        end
        cycle(100);

        wsel = 2'b01; cycle(600);
        wsel = 2'b10; cycle(520);
        wsel = 2'b00; cycle(520);

        fre = 1; cycle(3); fre = 0; cycle(60);
        rst = 1; cycle(1); rst = 0;
        cycle(270);

        en = 0; cycle(4);
        pulse_fre(); pulse_pha();
        en = 1; cycle(200);
        fre = 1; pha = 1; cycle(1); fre = 0; pha = 0; cycle(100);

`ifdef DDS_SWEEP_EN
        rst = 1; cycle(1); rst = 0;
        wsel = 2'b11; sweep = 1;
        cycle(900);
        sweep = 0;
        cycle(20);
`endif

        for (int i = 0; i < 2500; i++) begin
            rst  = ($urandom_range(0, 599) == 0);
            en   = ($urandom_range(0, 63) != 0);
            fre  = ($urandom_range(0, 15) == 0);
            pha  = ($urandom_range(0, 15) == 0);
            wsel = 2'($urandom_range(0, 3));
`ifdef DDS_SWEEP_EN
            sweep = ($urandom_range(0, 3) == 0);
`endif
            cycle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
